tv_gen_param: RTL

TV_GEN_PARAM -- requirements
Module: tv_gen_param

---
 rtl/tv_gen_param.sv | 84 ++++++++
 1 files changed

// File: rtl/tv_gen_param.sv
// tv_gen_param: parameterised test-vector generator (binary up/down, Gray, walking-one) with valid/ready handshake
module tv_gen_param #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic             i_loop,
  input  logic             i_stop,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_vec,
  output logic             o_valid,
  output logic             o_last,
  output logic             o_busy,
  output logic             o_done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_nstate;
  logic [WIDTH-1:0] r_idx, w_nidx, r_vec;
  logic [1:0]       r_mode, w_nmode;
  logic             r_loop, w_nloop;
  logic             r_valid, r_last, r_busy, r_done;
  logic             w_xfer, w_end, w_run;
  function automatic logic [WIDTH-1:0] vec_of(input logic [1:0] m, input logic [WIDTH-1:0] idx);
    return m == 2'b00 ? idx : m == 2'b01 ? idx ^ (idx >> 1) : m == 2'b10 ? WIDTH'(1) << idx : ~idx;
  endfunction
  function automatic logic last_of(input logic [1:0] m, input logic [WIDTH-1:0] idx);
    return m == 2'b10 ? idx == WIDTH'(WIDTH - 1) : &idx;
  endfunction
  assign w_xfer = r_valid & i_ready;
  assign w_end  = w_xfer & r_last;
  assign w_run  = w_nstate == RUN;
  // next state, index and latched run settings
  always_comb begin
    w_nstate = r_state;
    w_nidx   = r_idx;
    w_nmode  = r_mode;
    w_nloop  = r_loop;
    case (r_state)
      IDLE: if (i_start) begin
        w_nstate = RUN;
        w_nidx   = '0;
        w_nmode  = i_mode;
        w_nloop  = i_loop;
      end
      RUN: begin
        w_nstate = i_stop ? IDLE : (w_end && !r_loop) ? DONE : RUN;
        w_nidx   = w_end ? '0 : w_xfer ? r_idx + WIDTH'(1) : r_idx;
      end
      DONE: w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end
  // state and registered outputs, derived from the next state so no input reaches an output combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_mode  <= 2'b00;
      r_loop  <= 1'b0;
      r_vec   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_idx   <= w_nidx;
      r_mode  <= w_nmode;
      r_loop  <= w_nloop;
      r_vec   <= w_run ? vec_of(w_nmode, w_nidx) : '0;
      r_valid <= w_run;
      r_last  <= w_run && last_of(w_nmode, w_nidx);
      r_busy  <= w_run;
      r_done  <= w_nstate == DONE;
    end
  end
  assign o_vec   = r_vec;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
endmodule
